// File: rtl/handshake_input.sv
// Receiving end of a valid/ready byte stream.
// Buffers accepted values in a small FIFO and re-presents them downstream.
// Checks the stream against an incrementing sequence and reports a count
// and a sticky first-error capture.
module handshake_input #(
    parameter int          WIDTH = 8,
    parameter int          DEPTH = 4,
    parameter int unsigned START = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_value,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [15:0]      o_count,
    output logic             o_error,
    output logic [WIDTH-1:0] o_error_value
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               OCC_W   = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
    localparam logic [WIDTH-1:0] START_C = WIDTH'(START);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [15:0]      count_q, count_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] error_value_q, error_value_d;
    logic [WIDTH-1:0] expected_q, expected_d;

    logic accept;
    logic drain;

    assign accept = i_valid & ready_q;
    assign drain  = valid_q & i_ready;

    // FIFO pointers, occupancy and the registered downstream view of the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, drain})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        ready_d = (occ_d < DEPTH_C);
        valid_d = (occ_d != '0);
        // A single remaining entry that is being written this edge is the
        // new head; memory does not hold it yet, so take it from the input.
        if (occ_d == '0) begin
            value_d = '0;
        end else if (accept && (occ_d == OCC_W'(1))) begin
            value_d = i_value;
        end else begin
            value_d = mem_q[rd_ptr_d];
        end
    end

    // Sequence checker and saturating transfer counter.
    always_comb begin
        expected_d    = expected_q;
        error_d       = error_q;
        error_value_d = error_value_q;
        count_d       = count_q;
        if (accept) begin
            expected_d = i_value + ONE_C;
            if ((i_value != expected_q) && !error_q) begin
                error_d       = 1'b1;
                error_value_d = i_value;
            end
            if (count_q != 16'hFFFF) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // FIFO storage; stale contents are harmless since reset clears the pointers.
    always_ff @(posedge clock) begin
        if (reset_n && accept) begin
            mem_q[wr_ptr_q] <= i_value;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            ready_q       <= 1'b0;
            valid_q       <= 1'b0;
            value_q       <= '0;
            count_q       <= '0;
            error_q       <= 1'b0;
            error_value_q <= '0;
            expected_q    <= START_C;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            ready_q       <= ready_d;
            valid_q       <= valid_d;
            value_q       <= value_d;
            count_q       <= count_d;
            error_q       <= error_d;
            error_value_q <= error_value_d;
            expected_q    <= expected_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_value       = value_q;
    assign o_count       = count_q;
    assign o_error       = error_q;
    assign o_error_value = error_value_q;

endmodule
